// File: rtl/spi_slave_pkg.sv
// Shared types and command encodings for the SPI slave RAM front-end.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        PAYLOAD = 3'd2,
        REQ     = 3'd3,
        WAIT_TX = 3'd4,
        SHIFT   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-load shift register driving MISO; output enable follows load/abort.
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         abort,
    input  logic [W-1:0] din,
    output logic         miso,
    output logic         miso_oe
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            miso_oe <= 1'b0;
        end else if (abort) begin
            miso_oe <= 1'b0;
        end else if (load) begin
            sr      <= din;
            miso_oe <= 1'b1;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    // Gating with the enable keeps MISO at 0 whenever no read data is on the line.
    assign miso = miso_oe & sr[W-1];

endmodule

// File: rtl/spi_slave_ram_if.sv
// SPI slave front-end: deserialises {cmd, payload} frames into RAM requests and serialises read data.
module spi_slave_ram_if
    import spi_slave_pkg::*;
#(
    parameter int W          = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         SS_n,
    input  logic         MOSI,
    output logic         MISO,
    output logic         miso_oe,
    output logic [W+1:0] rx_data,
    output logic         rx_valid,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         frame_err,
    output logic         proto_err,
    output logic [2:0]   state_dbg
);

    localparam int CW = $clog2(W + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    state_t          state, next_state;
    logic [1:0]      cmd;
    logic [W-1:0]    rx_sr;
    logic [CW-1:0]   bit_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            rd_addr_seen;

    logic cmd_shift, pay_shift, cnt_clr, cnt_inc;
    logic rx_valid_d, frame_err_d, proto_err_d, set_rd_seen;
    logic tmo_clr, tmo_inc, tx_load, tx_shift, tx_abort;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cmd_shift   = 1'b0;
        pay_shift   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        proto_err_d = 1'b0;
        set_rd_seen = 1'b0;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        tx_abort    = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    next_state = CMD;
                    cnt_clr    = 1'b1;
                end
            end
            CMD: begin
                if (SS_n) begin
                    next_state  = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    cmd_shift = 1'b1;
                    if (bit_cnt == CW'(1)) begin
                        next_state = PAYLOAD;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (SS_n) begin
                    next_state  = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    pay_shift = 1'b1;
                    if (bit_cnt == CW'(W - 1)) begin
                        // A read-data request is meaningless until some read address was issued.
                        if (cmd == CMD_RD_DATA && !rd_addr_seen) begin
                            next_state  = DONE;
                            proto_err_d = 1'b1;
                        end else begin
                            next_state = REQ;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            REQ: begin
                rx_valid_d  = 1'b1;
                set_rd_seen = (cmd == CMD_RD_ADDR);
                if (cmd == CMD_RD_DATA) begin
                    next_state = WAIT_TX;
                    tmo_clr    = 1'b1;
                end else begin
                    next_state = DONE;
                end
            end
            WAIT_TX: begin
                if (SS_n) begin
                    next_state = IDLE;
                end else if (tx_valid) begin
                    next_state = SHIFT;
                    tx_load    = 1'b1;
                    cnt_clr    = 1'b1;
                end else if (tmo_cnt == TW'(TX_TIMEOUT - 1)) begin
                    next_state  = DONE;
                    proto_err_d = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            SHIFT: begin
                if (SS_n) begin
                    next_state = IDLE;
                    tx_abort   = 1'b1;
                end else if (bit_cnt == CW'(W - 1)) begin
                    next_state = DONE;
                    tx_abort   = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            DONE: begin
                if (SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd          <= '0;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            proto_err    <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            proto_err <= proto_err_d;
            if (cmd_shift)   cmd   <= {cmd[0], MOSI};
            if (pay_shift)   rx_sr <= W'({rx_sr, MOSI});
            if (rx_valid_d)  rx_data <= {cmd, rx_sr};
            if (set_rd_seen) rd_addr_seen <= 1'b1;
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + CW'(1);
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    spi_tx_shifter #(.W(W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .shift   (tx_shift),
        .abort   (tx_abort),
        .din     (tx_data),
        .miso    (MISO),
        .miso_oe (miso_oe)
    );

endmodule

// File: doc/spi_slave_ram_if.md
# spi_slave_ram_if

Parametrised SPI slave front-end for the single-port RAM. It deserialises command frames from MOSI into parallel RAM requests (`rx_data`/`rx_valid`) and serialises RAM read data (`tx_data`/`tx_valid`) onto MISO. It generalises the original fixed 10-bit/8-bit slave to any address/data width. It adds frame-abort detection, a read-response timeout, an explicit MISO output-enable and error reporting. The RAM is instantiated by the parent, not inside this block.

## Interface
- `W`, default 8: RAM address and data width; payload bits per frame.
- `TX_TIMEOUT`, default 16: maximum cycles to wait for `tx_valid` after a read-data request; minimum 1.
- `clk`  in  1  system clock; SPI bits are sampled on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial input, MSB first.
- `MISO`  out  1  serial output, MSB first.
- `miso_oe`  out  1  high while MISO carries valid read data.
- `rx_data`  out  W+2  `{cmd[1:0], payload[W-1:0]}` sent to the RAM.
- `rx_valid`  out  1  one-cycle strobe qualifying `rx_data`.
- `tx_data`  in  W  read data returned by the RAM.
- `tx_valid`  in  1  qualifies `tx_data`.
- `frame_err`  out  1  one-cycle pulse: `SS_n` rose before the payload completed.
- `proto_err`  out  1  one-cycle pulse: read-data request with no prior read address, or `tx_valid` timeout.

## Operation
- Command codes:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- States: IDLE, CMD, PAYLOAD, REQ, WAIT_TX, SHIFT, DONE.
- IDLE:
  - `SS_n`=0 → CMD.
  - MOSI is not sampled on the entry cycle.
- CMD: samples 2 bits into cmd (cmd[1] first) → PAYLOAD.
- PAYLOAD: samples W bits, MSB first.
  - After bit W, go to REQ.
  - Exception: if cmd=11 and `rd_addr_seen`=0, pulse `proto_err` and go to DONE with no `rx_valid`.
- REQ:
  - `rx_valid`=1 for one cycle with the assembled `rx_data`.
  - cmd=10 sets `rd_addr_seen`.
  - cmd 00/01/10 → DONE; cmd 11 → WAIT_TX.
  - Payload bits of cmd 11 are don't-care but are forwarded unchanged.
- WAIT_TX:
  - `tx_valid`=1 latches `tx_data` into the shift register and → SHIFT.
  - After TX_TIMEOUT cycles with no `tx_valid`: pulse `proto_err` → DONE.
- SHIFT:
  - Drives W bits MSB first, one per cycle; `miso_oe`=1.
  - After the last bit → DONE.
- DONE: waits for `SS_n`=1 → IDLE. MOSI is ignored.
- `SS_n`=1 in CMD or PAYLOAD:
  - Pulse `frame_err`, discard the partial frame, → IDLE.
  - No `rx_valid`.
- `SS_n`=1 in WAIT_TX or SHIFT → IDLE; `miso_oe` drops the next cycle. No error is raised (master-side early release is legal).
- `tx_valid` outside WAIT_TX is ignored.
- `rd_addr_seen` is cleared only by reset. It persists across frames.

## Timing
- Reset values: state IDLE, `MISO`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `proto_err`=0, `rd_addr_seen`=0.
- T0 is the first edge that sees `SS_n`=0.
  - Cmd bits are sampled at T1 and T2.
  - Payload bits are sampled at T3..T2+W.
  - `rx_valid` is high in the cycle after edge T3+W.
  - For W=8, that is the cycle after edge T11.
- Read data:
  - `tx_valid` sampled at edge Tk puts `tx_data[W-1]` on MISO, with `miso_oe`=1, after edge Tk.
  - `tx_data[0]` is on MISO after edge Tk+W-1.
  - `miso_oe` drops after edge Tk+W.
- Timeout counts edges in WAIT_TX. `tx_valid` on the TX_TIMEOUT-th edge is still accepted.
- `MISO` returns to 0 whenever `miso_oe`=0.
- Reset asserted mid-frame clears all state immediately, including `rd_addr_seen`.
- Counter width is `$clog2(W+1)`. The timeout counter width is `$clog2(TX_TIMEOUT+1)`.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum;
  - command constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
- Sub-module `spi_tx_shifter` (param W): load/shift register producing `MISO` and `miso_oe`, with load and abort inputs.
- The top level holds the FSM, RX shift register, bit counter and timeout counter.

## Test plan
- W=8, frame `00` + 0xA5 → `rx_valid` one cycle after edge T11 with `rx_data`=10'h0A5; no errors.
- Frame `11` + 0x00 immediately after reset → `proto_err` pulse, no `rx_valid`, `miso_oe` stays 0.
- Frame `10` + 0x07, then `11` + xx, with `tx_valid`/0xC3 arriving 2 cycles after `rx_valid` → MISO sequence 1,1,0,0,0,0,1,1 with `miso_oe`=1 for exactly 8 cycles.
- `SS_n` raised after 5 payload bits → `frame_err` pulse, no `rx_valid`; the next frame `01` + 0x3C yields `rx_data`=10'h13C.
- Read data with `tx_valid` withheld, TX_TIMEOUT=16 → `proto_err` on the 17th WAIT_TX cycle; `tx_valid` on the 16th edge is accepted.
- `rst_n` pulsed low during SHIFT → `MISO`=0 and `miso_oe`=0 immediately; a subsequent `11` frame raises `proto_err`.
